// File: rtl/writeback_queue.sv
// writeback_queue
//   Small FIFO that merges ALU and load results into a single register-file
//   write port. ALU has priority; both sources may enqueue on the same edge
//   (ALU entry first). One entry is popped per cycle onto the registered
//   write port. Combinational hazard lookup against the queued entries.
// Ports
//   clock, reset                    : single clock, synchronous active-high reset
//   alu_valid/alu_reg/alu_data      : ALU result offer; alu_ready accepts
//   load_valid/load_reg/load_data   : load result offer; load_ready accepts
//   query_reg_1/2 -> hazard_1/2     : decode-stage pending-write check
//   write_reg/write_data/write_enable : registered register-file write port
//   count                           : occupied FIFO entries
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_reg,
    input  logic [31:0]              alu_data,
    output logic                     alu_ready,
    input  logic                     load_valid,
    input  logic [4:0]               load_reg,
    input  logic [31:0]              load_data,
    output logic                     load_ready,
    input  logic [4:0]               query_reg_1,
    input  logic [4:0]               query_reg_2,
    output logic                     hazard_1,
    output logic                     hazard_2,
    output logic [4:0]               write_reg,
    output logic [31:0]              write_data,
    output logic                     write_enable,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          we_q, we_d;
    logic [4:0]    wreg_q, wreg_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [4:0]    mem_reg_q  [DEPTH];
    logic [4:0]    mem_reg_d  [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [31:0]   mem_data_d [DEPTH];

    logic [CW-1:0] free;
    logic          alu_enq, load_enq, pop;
    logic [AW-1:0] ld_slot;
    logic [DEPTH-1:0] occ;

    // Readiness looks only at the registered count, so a same-cycle pop
    // never feeds back into the handshake.
    always_comb begin
        free       = CW'(DEPTH) - count_q;
        alu_ready  = (free != '0);
        load_ready = (free >= CW'(2)) || ((free != '0) && !alu_valid);
    end

    always_comb begin
        // Register 0 writes are accepted but dropped.
        alu_enq  = alu_valid  && alu_ready  && (alu_reg  != 5'd0);
        load_enq = load_valid && load_ready && (load_reg != 5'd0);
        pop      = (count_q != '0);

        rd_ptr_d   = rd_ptr_q;
        we_d       = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        mem_reg_d  = mem_reg_q;
        mem_data_d = mem_data_q;

        if (pop) begin
            we_d     = 1'b1;
            wreg_d   = mem_reg_q[rd_ptr_q];
            wdata_d  = mem_data_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        // Load lands behind the ALU entry when both enqueue this edge.
        ld_slot = wr_ptr_q + AW'(alu_enq);
        if (alu_enq) begin
            mem_reg_d[wr_ptr_q]  = alu_reg;
            mem_data_d[wr_ptr_q] = alu_data;
        end
        if (load_enq) begin
            mem_reg_d[ld_slot]  = load_reg;
            mem_data_d[ld_slot] = load_data;
        end

        wr_ptr_d = wr_ptr_q + AW'(alu_enq) + AW'(load_enq);
        count_d  = count_q + CW'(alu_enq) + CW'(load_enq) - CW'(pop);
    end

    // An entry is live when its distance from the head is below count.
    // The entry already on the write port has left the FIFO, so it never
    // raises a hazard (the register file commits it on the negedge).
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] off;
            off    = AW'(i) - rd_ptr_q;
            occ[i] = ({1'b0, off} < count_q);
        end
    end

    always_comb begin
        hazard_1 = 1'b0;
        hazard_2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && (mem_reg_q[i] == query_reg_1)) hazard_1 = 1'b1;
            if (occ[i] && (mem_reg_q[i] == query_reg_2)) hazard_2 = 1'b1;
        end
        if (query_reg_1 == 5'd0) hazard_1 = 1'b0;
        if (query_reg_2 == 5'd0) hazard_2 = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            wreg_q   <= 5'd0;
            wdata_q  <= 32'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count and pointers.
    always_ff @(posedge clock) begin
        mem_reg_q  <= mem_reg_d;
        mem_data_q <= mem_data_d;
    end

    assign write_enable = we_q;
    assign write_reg    = wreg_q;
    assign write_data   = wdata_q;
    assign count        = count_q;

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Port clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port alu_valid  input  1  ALU result offered.
REQ-005 Port alu_reg  input  5  ALU destination register.
REQ-006 Port alu_data  input  32  ALU result.
REQ-007 Port alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high.
REQ-008 Port load_valid  input  1  load result offered.
REQ-009 Port load_reg  input  5  load destination register.
REQ-010 Port load_data  input  32  load result.
REQ-011 Port load_ready  output  1  load result accepted this cycle when load_valid is also high.
REQ-012 Port query_reg_1, query_reg_2  input  5 each  decode-stage source registers.
REQ-013 Port hazard_1, hazard_2  output  1 each  queried register has a pending write.
REQ-014 Port write_reg  output  5  register-file write address.
REQ-015 Port write_data  output  32  register-file write data.
REQ-016 Port write_enable  output  1  register-file write strobe.
REQ-017 Port count  output  log2(DEPTH)+1  occupied FIFO entries.

Function
REQ-018 free = DEPTH - count; ready SHALL derive from registered count only, not from the same-cycle dequeue.
REQ-019 alu_ready SHALL be (free >= 1); ALU has priority.
REQ-020 load_ready SHALL be (free >= 2) or (free >= 1 and not alu_valid).
REQ-021 Handshake: a transfer SHALL occur on a rising edge where valid and ready are both high; no transfer otherwise.
REQ-022 A source SHALL hold its valid, reg and data stable until transfer; the block SHALL NOT depend on this for correctness.
REQ-023 Simultaneous ALU and load transfers SHALL enqueue ALU first, then load, in one edge.
REQ-024 A transfer with reg = 0 SHALL be accepted and discarded: not enqueued, no write, count unchanged.
REQ-025 When count > 0 at a rising edge, the head SHALL be popped and registered onto write_reg/write_data with write_enable = 1 for the following cycle.
REQ-026 When count = 0 at a rising edge, write_enable SHALL be 0 the following cycle; write_reg/write_data SHALL hold.
REQ-027 Latency: a result accepted at edge t into an empty FIFO SHALL present write_enable = 1 from edge t+1 to t+2.
REQ-028 Throughput: one write per cycle; writes SHALL occur in acceptance order.
REQ-029 Registered outputs SHALL be stable from posedge, so a register file sampling on negedge captures them mid-cycle.
REQ-030 count after an edge SHALL equal count + enqueues - (count > 0 ? 1 : 0); it SHALL never exceed DEPTH or underflow.
REQ-031 Read/write pointers SHALL wrap modulo DEPTH.
REQ-032 hazard_k SHALL be combinational: 1 iff query_reg_k != 0 and it matches the reg of any occupied FIFO entry.
REQ-033 The entry on the write port SHALL NOT raise hazards; the register file commits it at negedge of that cycle.
REQ-034 Duplicate destinations in the FIFO SHALL all be written in order; the last write wins.

Reset
REQ-035 When reset is high at a rising edge: count = 0, pointers = 0, write_enable = 0, write_reg = 0, write_data = 0.
REQ-036 Reset SHALL take priority over enqueue and dequeue in the same edge; all queued entries SHALL be discarded, with no write emitted.
REQ-037 Outputs after reset: alu_ready = 1, load_ready = 1, hazard_1 = hazard_2 = 0.

Verification
REQ-038 Single ALU result (r5, 0x1234_5678) into empty FIFO at edge t -> write_enable = 1, write_reg = 5, write_data = 0x1234_5678 during t+1..t+2 only; count returns to 0.
REQ-039 ALU (r3, 0xA) and load (r4, 0xB) both valid, count = 0 -> both accepted in one edge; writes r3, then r4 on consecutive cycles.
REQ-040 DEPTH = 4; continuous ALU and load traffic with count = 3 -> alu_ready = 1, load_ready = 0; count stays at or below 4; no entry lost or reordered.
REQ-041 Enqueue r7, then query_reg_1 = 7, query_reg_2 = 0 -> hazard_1 = 1 while r7 is queued and 0 once r7 reaches the write port; hazard_2 = 0 throughout.
REQ-042 ALU transfer with alu_reg = 0 -> accepted, count unchanged, no write_enable pulse.
REQ-043 Reset asserted with count = 3 -> next cycle count = 0, write_enable = 0, all hazards 0; the queued entries are never written.
